// File: rtl/i2c_master_core.sv
// Single-byte I2C bus master: START, 7-bit address + R/W, one data byte written or read, STOP.
// Only SCL and SDA edges are produced here; a pull-up on SDA is assumed outside.
//
// state       | meaning
// IDLE        | bus released (SCL=1, SDA=Z), ready after first clk
// START       | SDA pulled low while SCL high for half a period
// ADDR        | shift out addr[6:0] then rw, MSB first
// ADDR_ACK    | SDA released; 0 = slave present
// WRITE       | shift out latched data byte
// WRITE_ACK   | SDA released for the slave ACK, result ignored
// READ        | SDA released, 8 bits sampled into shift register
// READ_NACK   | master drives 1 to end a single-byte read
// STOP_LOW    | SCL low, SDA low
// STOP_HIGH   | SCL high, SDA still low
// STOP_HOLD   | SDA high with SCL high, then back to IDLE
module i2c_master_core #(
    parameter int DIVIDE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    localparam int CW = $clog2(DIVIDE);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVIDE / 2 - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_NACK,
        ST_STOP_LOW,
        ST_STOP_HIGH,
        ST_STOP_HOLD
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    tx_q;
    logic [7:0]    data_out_q;
    logic          rw_q;
    logic          scl_q;
    logic          sda_oe_q;
    logic          sda_out_q;
    logic          ready_q;
    logic          sda_in;
    logic          half_done;

    assign sda_in    = i2c_sda;
    assign half_done = (cnt_q == '0);

    assign i2c_scl  = scl_q;
    assign i2c_sda  = sda_oe_q ? sda_out_q : 1'bz;
    assign data_out = data_out_q;
    assign ready    = ready_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            data_out_q <= '0;
            rw_q       <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_out_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    scl_q    <= 1'b1;
                    sda_oe_q <= 1'b0;
                    if (ready_q && enable) begin
                        shift_q   <= {addr, rw};
                        tx_q      <= data_in;
                        rw_q      <= rw;
                        ready_q   <= 1'b0;
                        sda_oe_q  <= 1'b1;
                        sda_out_q <= 1'b0;
                        cnt_q     <= HALF_LAST;
                        state_q   <= ST_START;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (half_done) begin
                        state_q   <= ST_ADDR;
                        scl_q     <= 1'b0;
                        sda_out_q <= shift_q[7];
                        bit_q     <= 3'd7;
                        cnt_q     <= HALF_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP_LOW: begin
                    if (half_done) begin
                        state_q <= ST_STOP_HIGH;
                        scl_q   <= 1'b1;
                        cnt_q   <= HALF_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP_HIGH: begin
                    if (half_done) begin
                        state_q   <= ST_STOP_HOLD;
                        sda_out_q <= 1'b1;
                        cnt_q     <= HALF_LAST;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP_HOLD: begin
                    if (half_done) begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    // Bit slots: low half then high half; SDA moves and SDA is sampled only at the end of the high half.
                    if (!half_done) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!scl_q) begin
                        scl_q <= 1'b1;
                        cnt_q <= HALF_LAST;
                    end else begin
                        scl_q <= 1'b0;
                        cnt_q <= HALF_LAST;
                        case (state_q)
                            ST_ADDR, ST_WRITE: begin
                                if (bit_q != 3'd0) begin
                                    bit_q     <= bit_q - 1'b1;
                                    shift_q   <= {shift_q[6:0], 1'b0};
                                    sda_out_q <= shift_q[6];
                                end else begin
                                    state_q  <= (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                                    sda_oe_q <= 1'b0;
                                end
                            end
                            ST_ADDR_ACK: begin
                                if (sda_in) begin
                                    state_q   <= ST_STOP_LOW;
                                    sda_oe_q  <= 1'b1;
                                    sda_out_q <= 1'b0;
                                end else if (rw_q) begin
                                    state_q  <= ST_READ;
                                    bit_q    <= 3'd7;
                                    sda_oe_q <= 1'b0;
                                end else begin
                                    state_q   <= ST_WRITE;
                                    bit_q     <= 3'd7;
                                    shift_q   <= tx_q;
                                    sda_oe_q  <= 1'b1;
                                    sda_out_q <= tx_q[7];
                                end
                            end
                            ST_READ: begin
                                shift_q <= {shift_q[6:0], sda_in};
                                if (bit_q != 3'd0) begin
                                    bit_q <= bit_q - 1'b1;
                                end else begin
                                    data_out_q <= {shift_q[6:0], sda_in};
                                    state_q    <= ST_READ_NACK;
                                    sda_oe_q   <= 1'b1;
                                    sda_out_q  <= 1'b1;
                                end
                            end
                            ST_WRITE_ACK, ST_READ_NACK: begin
                                state_q   <= ST_STOP_LOW;
                                sda_oe_q  <= 1'b1;
                                sda_out_q <= 1'b0;
                            end
                            default: begin
                                state_q  <= ST_IDLE;
                                sda_oe_q <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: bus monitor + open-drain slave model, table vectors, random frames
// and hand-written sequences for held enable, mid-frame reset and idle bus.
module tb_i2c_master_core;

    localparam int DIVIDE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       ready;
    wire        i2c_sda;
    wire        i2c_scl;

    logic       slv_oe = 1'b0;
    logic [6:0] slv_addr = 7'h55;
    logic [7:0] slv_rdata = 8'h00;

    pullup (i2c_sda);
    assign i2c_sda = slv_oe ? 1'b0 : 1'bz;

    i2c_master_core #(.DIVIDE(DIVIDE)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .enable   (enable),
        .rw       (rw),
        .data_out (data_out),
        .ready    (ready),
        .i2c_sda  (i2c_sda),
        .i2c_scl  (i2c_scl)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: expected SDA level at every SCL rise of a frame, final data_out, frame length.
    bit         exp_bits[$];
    bit         last_bits[$];
    bit         samples[$];
    logic [7:0] model_dout = 8'h00;
    int         exp_cyc = 0;

    task automatic model_frame(input logic [6:0] a, input logic [7:0] d, input logic r,
                               input logic [6:0] s, input logic [7:0] rd);
        logic       acked;
        logic [7:0] b;
        acked = (a == s);
        exp_bits.delete();
        for (int i = 6; i >= 0; i--) exp_bits.push_back(a[i]);
        exp_bits.push_back(r);
        exp_bits.push_back(!acked);
        if (acked) begin
            b = r ? rd : d;
            for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
            exp_bits.push_back(r);  // read: master NACK (1); write: slave ACK (0)
        end
        exp_bits.push_back(1'b0);  // SCL rise of the STOP condition, SDA still low
        exp_cyc = (acked ? 18 : 9) * DIVIDE + 2 * DIVIDE;
        if (r && acked) model_dout = rd;
    endtask

    function automatic bit frame_ok();
        if (last_bits.size() != exp_bits.size()) return 1'b0;
        foreach (last_bits[i]) if (last_bits[i] != exp_bits[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] pack_last();
        logic [31:0] v = '0;
        foreach (last_bits[i]) v = {v[30:0], last_bits[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack_exp();
        logic [31:0] v = '0;
        foreach (exp_bits[i]) v = {v[30:0], exp_bits[i]};
        return v;
    endfunction

    // Bus monitor, sampled mid-cycle so simultaneous SCL/SDA updates never look like START/STOP.
    logic       mon_clr = 1'b1;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       in_frame = 1'b0;
    int         bit_no = 0;
    logic [7:0] rx_byte = '0;
    int         starts = 0;
    int         stops = 0;
    int         stray = 0;
    int         frames_bad = 0;

    initial forever begin
        @(negedge clk);
        if (mon_clr) begin
            in_frame   = 1'b0;
            bit_no     = 0;
            rx_byte    = '0;
            starts     = 0;
            stops      = 0;
            stray      = 0;
            frames_bad = 0;
            samples.delete();
            last_bits.delete();
        end else begin
            if (p_scl && i2c_scl) begin
                if (p_sda && !i2c_sda) begin
                    in_frame = 1'b1;
                    bit_no   = 0;
                    samples.delete();
                    starts++;
                end else if (!p_sda && i2c_sda && in_frame) begin
                    in_frame  = 1'b0;
                    stops++;
                    last_bits = samples;
                    if (!frame_ok()) frames_bad++;
                end
            end
            if (!p_scl && i2c_scl) begin
                if (in_frame) begin
                    samples.push_back(i2c_sda);
                    bit_no++;
                    if (bit_no <= 8) rx_byte = {rx_byte[6:0], i2c_sda};
                end else begin
                    stray++;
                end
            end
            if (p_scl && !i2c_scl && !in_frame) stray++;
        end
        p_scl = i2c_scl;
        p_sda = i2c_sda;
    end

    // Open-drain slave: releases on SCL fall, then pulls low for ACKs / zero read bits.
    initial begin : slave
        int   nb;
        logic ack;
        logic drv;
        forever begin
            @(negedge i2c_scl);
            slv_oe = 1'b0;
            nb  = bit_no + 1;
            ack = in_frame && (rx_byte[7:1] == slv_addr);
            drv = 1'b0;
            if (ack && nb == 9) drv = 1'b1;
            else if (ack && rx_byte[0] && nb >= 10 && nb <= 17) drv = ~slv_rdata[17 - nb];
            else if (ack && !rx_byte[0] && nb == 18) drv = 1'b1;
            #1 slv_oe = drv;
        end
    end

    task automatic run_txn(input string tag, input logic [6:0] a, input logic [7:0] d, input logic r,
                           input logic [6:0] s, input logic [7:0] rd, input bit use_tbl, input logic [7:0] tbl_dout);
        int cyc;
        int st0, sp0, sy0;
        model_frame(a, d, r, s, rd);
        slv_addr  = s;
        slv_rdata = rd;
        st0 = starts;
        sp0 = stops;
        sy0 = stray;
        addr    = a;
        data_in = d;
        rw      = r;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        check({tag, ".accept"}, 32'(ready), 32'd0);
        cyc = 1;
        while (!ready && cyc < 30 * DIVIDE) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, ".done"}, 32'(ready), 32'd1);
        check({tag, ".len_ok"}, 32'((cyc >= exp_cyc - DIVIDE / 2) && (cyc <= exp_cyc + DIVIDE / 2)), 32'd1);
        check({tag, ".starts"}, 32'(starts - st0), 32'd1);
        check({tag, ".stops"}, 32'(stops - sp0), 32'd1);
        check({tag, ".nbits"}, 32'(last_bits.size()), 32'(exp_bits.size()));
        check({tag, ".bits"}, pack_last(), pack_exp());
        check({tag, ".dout"}, 32'(data_out), 32'(model_dout));
        if (use_tbl) check({tag, ".dout_tbl"}, 32'(data_out), 32'(tbl_dout));
        check({tag, ".stray_scl"}, 32'(stray - sy0), 32'd0);
    endtask

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       r;
        logic [6:0] s;
        logic [7:0] rd;
        logic [7:0] exp_dout;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[8];
        int   idle_bad;
        int   pulses, st0, sp0, fb0, n, cyc;
        logic [6:0] a, s;
        logic [7:0] d, rd;
        logic       r;

        tbl[0] = '{7'h55, 8'hAA, 1'b0, 7'h55, 8'h00, 8'h00};
        tbl[1] = '{7'h55, 8'h00, 1'b1, 7'h55, 8'h3C, 8'h3C};
        tbl[2] = '{7'h12, 8'h5A, 1'b0, 7'h55, 8'h00, 8'h3C};
        tbl[3] = '{7'h12, 8'h00, 1'b1, 7'h55, 8'hFF, 8'h3C};
        tbl[4] = '{7'h7F, 8'h00, 1'b1, 7'h7F, 8'hA5, 8'hA5};
        tbl[5] = '{7'h00, 8'hFF, 1'b0, 7'h00, 8'h00, 8'hA5};
        tbl[6] = '{7'h01, 8'h00, 1'b1, 7'h01, 8'h00, 8'h00};
        tbl[7] = '{7'h40, 8'h81, 1'b0, 7'h40, 8'h00, 8'h00};

        rst = 1'b0;
        mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.dout", 32'(data_out), 32'd0);
        check("rst.scl", 32'(i2c_scl), 32'd1);
        check("rst.sda", 32'(i2c_sda), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release.ready", 32'(ready), 32'd1);
        mon_clr = 1'b0;

        idle_bad = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (i2c_scl !== 1'b1 || i2c_sda !== 1'b1 || ready !== 1'b1) idle_bad++;
        end
        check("idle.bus", 32'(idle_bad), 32'd0);
        check("idle.stray_scl", 32'(stray), 32'd0);
        check("idle.starts", 32'(starts), 32'd0);

        for (int i = 0; i < 8; i++)
            run_txn($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].s, tbl[i].rd, 1'b1, tbl[i].exp_dout);

        for (int k = 0; k < 16; k++) begin
            a  = 7'($urandom);
            d  = 8'($urandom);
            r  = 1'($urandom);
            rd = 8'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? (a ^ 7'h2A) : a;
            run_txn($sformatf("rnd%0d", k), a, d, r, s, rd, 1'b0, 8'h00);
        end

        // Held enable: back-to-back identical write frames.
        model_frame(7'h55, 8'hAA, 1'b0, 7'h55, 8'h00);
        slv_addr = 7'h55;
        st0 = starts;
        sp0 = stops;
        fb0 = frames_bad;
        addr = 7'h55;
        data_in = 8'hAA;
        rw = 1'b0;
        enable = 1'b1;
        pulses = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        enable = 1'b0;
        cyc = 0;
        while (!ready && cyc < 30 * DIVIDE) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold.done", 32'(ready), 32'd1);
        n = starts - st0;
        check("hold.frames_in_range", 32'(n >= 5 && n <= 7), 32'd1);
        check("hold.stops", 32'(stops - sp0), 32'(n));
        check("hold.bad_frames", 32'(frames_bad - fb0), 32'd0);
        check("hold.ready_pulses", 32'(pulses == n - 1 || pulses == n), 32'd1);

        // Reset in the middle of the data byte.
        run_txn("pre_rst_read", 7'h55, 8'h00, 1'b1, 7'h55, 8'h3C, 1'b1, 8'h3C);
        slv_addr = 7'h55;
        addr = 7'h55;
        data_in = 8'hAA;
        rw = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.scl", 32'(i2c_scl), 32'd1);
        check("midrst.sda", 32'(i2c_sda), 32'd1);
        check("midrst.ready", 32'(ready), 32'd0);
        check("midrst.dout", 32'(data_out), 32'd0);
        mon_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.release_ready", 32'(ready), 32'd1);
        mon_clr = 1'b0;
        model_dout = 8'h00;
        run_txn("post_rst_write", 7'h55, 8'hAA, 1'b0, 7'h55, 8'h00, 1'b1, 8'h00);
        run_txn("post_rst_read", 7'h33, 8'h00, 1'b1, 7'h33, 8'h66, 1'b1, 8'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
Single-byte I2C bus master. On a request it issues START, a 7-bit address with R/W bit, and one data byte (write) or receives one byte (read), then issues STOP. It sits between a local controller (addr, data, enable/ready handshake) and the bidirectional SDA/SCL pins. A slave device model on the same wires answers ACKs and read data.

Parameters:
DIVIDE, 4, system clocks per SCL period (even, >=4). SCL low half = DIVIDE/2 clk, high half = DIVIDE/2 clk.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
addr  in  7  target slave address, latched at request
data_in  in  8  byte to write, latched at request
enable  in  1  transaction request, level-sensitive, sampled only while ready=1
rw  in  1  0 = write, 1 = read; latched at request
data_out  out  8  last byte received by a read
ready  out  1  1 = idle and able to accept a request
i2c_sda  inout  1  serial data; master drives 0/1 when it owns the bus, else Z (bench pull-up)
i2c_scl  inout  1  serial clock; always driven by master (push-pull), 1 when idle

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, ready=0, data_out=0x00, SDA=Z, SCL=1, divider cleared. Reset mid-transaction aborts immediately with no STOP.
- ready=1 only in IDLE with rst=1. First clk after reset release: ready=1.
- IDLE: if enable=1, latch {addr,rw} into shift register and data_in into tx register, ready->0 next clk, go START. enable ignored while ready=0. If enable is still high on return to IDLE, a new identical-request transaction starts (back-to-back).
- START: SCL held 1, SDA driven 1->0, held DIVIDE/2 clk, then SCL toggling begins.
- Bit timing: SDA changes only while SCL low (at start of low half); receiver samples on SCL rising edge. Each bit = DIVIDE clk.
- ADDR: 8 bits MSB first: addr[6]..addr[0], then rw.
- ADDR_ACK: SDA=Z for one bit; sampled 0 = ACK -> WRITE_DATA if rw=0, READ_DATA if rw=1; sampled 1 = NACK -> STOP.
- WRITE_DATA: 8 bits of latched data_in MSB first.
- WRITE_ACK: SDA=Z one bit, ACK/NACK sampled (not reported), then STOP.
- READ_DATA: SDA=Z, 8 bits sampled MSB first into shift register; data_out updated with full byte in the clk after 8th sample; data_out unchanged on writes and on NACKed reads.
- READ_NACK: master drives SDA=1 for one bit (single-byte read), then STOP.
- STOP: SCL low with SDA=0, SCL->1, then SDA 0->1 while SCL=1, hold DIVIDE/2 clk, return IDLE, ready=1.
- Idle bus: SCL=1, SDA=Z. Frame length (write or read, ACKed) = START + 18 bits + STOP ≈ 20*DIVIDE clk.
- SCL never toggles outside START..STOP. No clock stretching, no arbitration, no repeated start.

Test Plan:
- Write: addr=0x55, data_in=0xAA, rw=0, enable 1 for one request, slave ACKs -> SDA on SCL rises: 1010101,0,ACK(0),10101010,ACK(0); START/STOP edges with SCL=1; ready returns 1; data_out stays 0x00.
- Read: addr=0x55, rw=1, slave ACKs and returns 0x3C -> master NACKs (SDA=1 at 9th data bit), STOP, data_out=0x3C when ready=1.
- Address NACK: no slave at addr=0x12 (SDA pulled high) -> STOP right after ACK bit, no data bits clocked, ready=1, data_out unchanged.
- Held enable: enable=1 for 500 clk with write request -> repeated identical write frames, each with START/STOP, ready pulsing 1 between frames.
- Reset mid-frame: rst=0 during data bits -> next clk SCL=1, SDA=Z, ready=0, data_out=0x00; after release ready=1, new request completes normally.
- Idle: enable=0 -> SCL constant 1, SDA Z, ready=1 indefinitely.
